// File: rtl/acc_arbiter_if.sv
// ----------------------------------------------------------------------------
// acc_arbiter_if -- signal bundle between the two requesters, the matrix
// multiplier and the acc_arbiter.
//
//   req         [1:0]  level request per requester (bit0 = requester 0)
//   gnt         [1:0]  one-hot grant, owner of the operand/result path
//   sel                index of the granted requester (valid while gnt != 0)
//   ack         [1:0]  one-cycle completion pulse to the owner
//   acc_start          one-cycle start pulse to the matrix multiplier
//   acc_done           level "result valid" from the matrix multiplier
//   busy               arbiter is not idle
//   timeout_err        sticky WAIT-timeout flag
//   err_clr            synchronous clear of timeout_err
//
// Modports: slave  = arbiter side (drives gnt/sel/ack/acc_start/busy/err)
//           master = environment side (drives req/acc_done/err_clr)
// ----------------------------------------------------------------------------
interface acc_arbiter_if;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       sel;
  logic [1:0] ack;
  logic       acc_start;
  logic       acc_done;
  logic       busy;
  logic       timeout_err;
  logic       err_clr;

  modport slave (
    input  req, acc_done, err_clr,
    output gnt, sel, ack, acc_start, busy, timeout_err
  );

  modport master (
    output req, acc_done, err_clr,
    input  gnt, sel, ack, acc_start, busy, timeout_err
  );
endinterface

// File: rtl/acc_arbiter.sv
// ----------------------------------------------------------------------------
// acc_arbiter -- two-requester round-robin arbiter in front of a shared
// matrix-multiplier accelerator.
//
// One operation = IDLE -> START -> WAIT (>= 2 cycles) -> ACK -> IDLE.
// The owner is chosen in IDLE (single requester wins; on a tie the
// round-robin pointer decides) and holds the accelerator until ACK.
// The pointer flips to the non-owner every time ACK is left.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   acc_arbiter_if.slave (req, gnt, sel, ack, acc_start, acc_done,
//         busy, timeout_err, err_clr)
//
// Parameters:
//   TIMEOUT_CYCLES  maximum WAIT cycles before an abort (2..65535)
//
// Build option:
//   ACC_ARB_TIMEOUT_EN  when defined, a WAIT counter aborts the operation
//                       after TIMEOUT_CYCLES cycles without acc_done, still
//                       pulses ack and sets the sticky timeout_err. When
//                       undefined, no counter exists, WAIT lasts until
//                       acc_done and timeout_err is constant 0.
// ----------------------------------------------------------------------------
module acc_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic          clk,
  input  logic          rst,
  acc_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;   // requester currently holding the accelerator
  logic   ptr_q,   ptr_d;     // round-robin pointer: tie winner in IDLE
  logic   first_q, first_d;   // high during the first WAIT cycle only
  logic   pick_owner;
  logic   done_accept;
  logic   timeout_hit;

  // Tie-break only matters when both requesters are pending.
  assign pick_owner = (bus.req == 2'b10) ? 1'b1 :
                      (bus.req == 2'b01) ? 1'b0 : ptr_q;

  // acc_done may still be high from the previous operation; the first WAIT
  // cycle ignores it so a stale result is never taken as this one.
  assign done_accept = (state_q == ST_WAIT) && bus.acc_done && !first_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path leaves
    // it unassigned and no latch is inferred; blocking '=' is correct here.
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    first_d = first_q;

    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          state_d = ST_START;
          owner_d = pick_owner;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
        first_d = 1'b1;
      end
      ST_WAIT: begin
        first_d = 1'b0;
        if (done_accept || timeout_hit) state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        ptr_d   = ~owner_q;   // also taken after a timeout abort
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values; the reset branch is asynchronous and puts the FSM
    // in IDLE with the pointer on requester 0 without waiting for clk.
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      first_q <= first_d;
    end
  end

  // --------------------------------------------------------------------------
  // Optional WAIT timeout
  // --------------------------------------------------------------------------
`ifdef ACC_ARB_TIMEOUT_EN
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q;
  logic        err_q;

  // Counter is 0 in the first WAIT cycle, so CNT_LAST is reached in WAIT
  // cycle TIMEOUT_CYCLES and the abort leaves WAIT after exactly that many.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == ST_START) begin
      cnt_q <= '0;
    end else if (state_q == ST_WAIT) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // A done accepted in the last allowed cycle is a normal completion.
  assign timeout_hit = (state_q == ST_WAIT) && !done_accept && (cnt_q == CNT_LAST);

  // Set has priority over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end else if (bus.err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign bus.timeout_err = err_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs: pure decode of the registered state, so reset clears them
  // immediately.
  // --------------------------------------------------------------------------
  logic [1:0] gnt_c;
  logic [1:0] ack_c;
  logic       sel_c;
  logic       start_c;

  always_comb begin
    gnt_c   = 2'b00;
    ack_c   = 2'b00;
    sel_c   = 1'b0;
    start_c = 1'b0;
    unique case (state_q)
      ST_START: begin
        gnt_c[owner_q] = 1'b1;
        sel_c          = owner_q;
        start_c        = 1'b1;
      end
      ST_WAIT: begin
        gnt_c[owner_q] = 1'b1;
        sel_c          = owner_q;
      end
      ST_ACK: begin
        ack_c[owner_q] = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.gnt       = gnt_c;
  assign bus.ack       = ack_c;
  assign bus.sel       = sel_c;
  assign bus.acc_start = start_c;
  assign bus.busy      = (state_q != ST_IDLE);

`ifndef SYNTHESIS
  // Structural guarantees of the arbitration.
  a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(bus.gnt));
  a_ack_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(bus.ack));
  a_gnt_ack_excl : assert property (@(posedge clk) disable iff (rst)
                                    !((|bus.gnt) && (|bus.ack)));
`endif

endmodule

// File: tb/tb_acc_arbiter.sv
// ----------------------------------------------------------------------------
// tb_acc_arbiter -- self-checking bench for acc_arbiter.
// Each operation is described by its request pattern and the WAIT cycle in
// which acc_done rises; the expected owner, WAIT length, ack and error flag
// are derived from the arbitration rules in plain arithmetic. Directed
// operations cover the listed scenarios, then a randomized run follows.
// Build with +define+ACC_ARB_TIMEOUT_EN (for both RTL and bench) to check the
// timeout variant.
// ----------------------------------------------------------------------------
module tb_acc_arbiter;

  localparam int T = 16;
`ifdef ACC_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  acc_arbiter_if bus();

  acc_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_ptr = 0;     // requester favoured on the next tie
  bit exp_err = 1'b0;  // expected sticky error flag

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int owner_of(input int pat, input int ptr);
    if (pat == 1) return 0;
    if (pat == 2) return 1;
    return ptr;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, ".busy"},  32'(bus.busy),      32'd0);
    check({tag, ".gnt"},   32'(bus.gnt),       32'd0);
    check({tag, ".ack"},   32'(bus.ack),       32'd0);
    check({tag, ".start"}, 32'(bus.acc_start), 32'd0);
    check({tag, ".sel"},   32'(bus.sel),       32'd0);
    check({tag, ".err"},   32'(bus.timeout_err), 32'(exp_err));
  endtask

  // Called at a falling edge while the arbiter is idle; leaves at a falling
  // edge with the arbiter idle again.
  task automatic run_op(input string tag, input int pat, input int done_at,
                        input bit drop, input bit keep_done, input bit clr_last);
    int owner, accept, last;
    bit to;
    owner  = owner_of(pat, exp_ptr);
    accept = (done_at < 1) ? 1 : done_at;     // first WAIT cycle ignores done
    to     = TO_EN && (accept > T - 1);
    last   = to ? T - 1 : accept;             // index of the final WAIT cycle

    bus.req = 2'(pat);
    @(posedge clk); @(negedge clk);
    check({tag, ".start"},       32'(bus.acc_start), 32'd1);
    check({tag, ".start_gnt"},   32'(bus.gnt),       32'(1 << owner));
    check({tag, ".start_sel"},   32'(bus.sel),       32'(owner));
    check({tag, ".start_busy"},  32'(bus.busy),      32'd1);
    check({tag, ".start_ack"},   32'(bus.ack),       32'd0);
    if (drop) bus.req = 2'b00;

    for (int i = 0; i <= last; i++) begin
      @(posedge clk); @(negedge clk);
      check({tag, ".wait_gnt"},   32'(bus.gnt),         32'(1 << owner));
      check({tag, ".wait_sel"},   32'(bus.sel),         32'(owner));
      check({tag, ".wait_start"}, 32'(bus.acc_start),   32'd0);
      check({tag, ".wait_ack"},   32'(bus.ack),         32'd0);
      check({tag, ".wait_err"},   32'(bus.timeout_err), 32'(exp_err));
      bus.acc_done = (i >= done_at);
      if (clr_last && i == last) bus.err_clr = 1'b1;
    end

    @(posedge clk); @(negedge clk);
    if (to) exp_err = 1'b1;
    else if (clr_last) exp_err = 1'b0;
    check({tag, ".ack"},      32'(bus.ack),         32'(1 << owner));
    check({tag, ".ack_gnt"},  32'(bus.gnt),         32'd0);
    check({tag, ".ack_busy"}, 32'(bus.busy),        32'd1);
    check({tag, ".ack_err"},  32'(bus.timeout_err), 32'(exp_err));
    exp_ptr = 1 - owner;
    bus.err_clr = 1'b0;
    bus.req     = 2'b00;
    if (!keep_done) bus.acc_done = 1'b0;

    @(posedge clk); @(negedge clk);
    check_quiet({tag, ".idle"});
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    exp_ptr = 0;
    exp_err = 1'b0;
    #1;
    check_quiet({tag, ".async"});
    bus.req = 2'b00;
    bus.acc_done = 1'b0;
    bus.err_clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.req      = 2'b00;
    bus.acc_done = 1'b0;
    bus.err_clr  = 1'b0;
    #1;
    check_quiet("reset");
    @(negedge clk);
    rst = 1'b0;

    // Basic single-requester operation, done 5 cycles after start.
    run_op("basic", 1, 4, 1'b0, 1'b0, 1'b0);

    // Both requesting: alternation 0,1,0,1 starting from a fresh pointer.
    do_reset("rst_rr");
    for (int k = 0; k < 4; k++) begin
      check("rr_order", 32'(owner_of(3, exp_ptr)), 32'(k % 2));
      run_op("rr", 3, 2, 1'b0, 1'b0, 1'b0);
    end

    // Stale done held across START is masked in the first WAIT cycle.
    run_op("stale_a", 1, 2, 1'b0, 1'b1, 1'b0);
    run_op("stale_b", 2, 0, 1'b0, 1'b0, 1'b0);

    // Requester drops req during WAIT; operation still completes.
    run_op("drop", 1, 3, 1'b1, 1'b0, 1'b0);

    // Reset during WAIT: outputs clear at once, no ack, pointer back to 0.
    run_op("pre_rst", 1, 1, 1'b0, 1'b0, 1'b0);   // pointer now 1
    bus.req = 2'b11;
    @(posedge clk); @(negedge clk);
    check("mid_gnt", 32'(bus.gnt), 32'b10);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    exp_ptr = 0;
    exp_err = 1'b0;
    #1;
    check_quiet("mid_rst");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mid_rst_ack", 32'(bus.ack), 32'd0);
    end
    rst = 1'b0;
    run_op("post_rst", 3, 2, 1'b0, 1'b0, 1'b0);   // expects requester 0

    // Stuck-low done: timeout abort with sticky error, or endless WAIT.
    do_reset("rst_to");
    run_op("stuck", 1, 40, 1'b0, 1'b0, 1'b0);
    bus.err_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.err_clr = 1'b0;
    exp_err = 1'b0;
    check_quiet("err_clr");
    // Clear and timeout in the same cycle: set wins.
    run_op("clr_vs_set", 2, 40, 1'b0, 1'b0, 1'b1);
    bus.err_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.err_clr = 1'b0;
    exp_err = 1'b0;
    check_quiet("err_clr2");

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      int gap;
      run_op("rand", int'($urandom_range(1, 3)), int'($urandom_range(0, 20)),
             ($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 4) == 0);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); @(negedge clk);
        check_quiet("gap");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
